// File: rtl/whack_pkg.sv
// Shared definitions for the score display: digit count, score width,
// seven-segment glyphs (active-low {g,f,e,d,c,b,a}) and converter states.
package whack_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int SCORE_W    = 16;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element 0 is the leftmost entry, so the list reads 0..9.
  localparam logic [0:9][6:0] SEG_LUT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_BLANK;
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 16 shift iterations per conversion,
// result committed to bcd as one 20-bit write in the DONE state.
module bin2bcd_seq
  import whack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               done,
  output logic               busy
);

  localparam int SR_W = BCD_W + SCORE_W;

  conv_state_e       state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [3:0]        iter_q, iter_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[SCORE_W+4*i +: 4] >= 4'd5)
        t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          iter_d  = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d   = dabble(sr_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        bcd_d   = sr_q[SR_W-1:SCORE_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
    end
  end

  // Working registers are only meaningful inside SHIFT, so they carry no reset.
  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    iter_q <= iter_d;
  end

  assign bcd  = bcd_q;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/score_display.sv
// Score to 5-digit multiplexed common-anode 7-seg display.
// Define SCORE_LZ_BLANK_EN to blank leading-zero digits (units always shown).
module score_display
  import whack_pkg::*;
#(
  parameter int SCAN_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SCORE_W-1:0]  score,
  output logic [6:0]          seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [BCD_W-1:0]    bcd,
  output logic                bcd_valid,
  output logic                busy
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [SCORE_W-1:0]    shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  bcd_valid_q, bcd_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic                  start;
  logic                  conv_done;
  logic                  conv_busy;
  logic [BCD_W-1:0]      conv_bcd;
  logic [3:0]            nib;
  logic                  lz;

  // The converter only accepts start while IDLE, so a changed score is
  // picked up at the first IDLE cycle after any in-flight conversion.
  assign start = (pending_q || (score != shadow_q)) && !conv_busy;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (score),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  always_comb begin
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    bcd_valid_d = bcd_valid_q | conv_done;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    if (start) begin
      shadow_d  = score;
      pending_d = 1'b0;
    end
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end

    nib = conv_bcd[4*idx_q +: 4];
`ifdef SCORE_LZ_BLANK_EN
    lz = (idx_q != 3'd0) && ((conv_bcd >> (4*idx_q)) == '0);
`else
    lz = 1'b0;
`endif
    an_d  = {NUM_DIGITS{1'b1}};
    seg_d = SEG_BLANK;
    if (bcd_valid_q) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = lz ? SEG_BLANK : seg_decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b1;
      bcd_valid_q <= 1'b0;
      an_q        <= {NUM_DIGITS{1'b1}};
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      bcd_valid_q <= bcd_valid_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd       = conv_bcd;
  assign bcd_valid = bcd_valid_q;
  assign busy      = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display against a decimal-arithmetic reference
// model of conversion timing and the digit scan (SCAN_DIV=4).
module tb_score_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] score = 16'd0;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;

  score_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .score     (score),
    .seg       (seg),
    .an        (an),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  // Reference model state: committed value as an integer, conversion countdown.
  int         m_val     = 0;
  int         m_cap     = 0;
  int         m_shadow  = 0;
  int         m_conv    = 0;
  int         m_cnt     = 0;
  int         m_idx     = 0;
  bit         m_pending = 1'b1;
  bit         m_valid   = 1'b0;
  logic [4:0] m_an      = 5'h1F;
  logic [6:0] m_seg     = 7'h7F;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int val, input int idx);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
`ifdef SCORE_LZ_BLANK_EN
    if (idx > 0 && val < p) return 7'h7F;
`endif
    return glyph_tab[(val / p) % 10];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_val = 0; m_cap = 0; m_shadow = 0; m_conv = 0; m_cnt = 0; m_idx = 0;
      m_pending = 1'b1; m_valid = 1'b0; m_an = 5'h1F; m_seg = 7'h7F;
    end else begin
      m_an  = m_valid ? ~(5'b00001 << m_idx) : 5'h1F;
      m_seg = m_valid ? glyph(m_val, m_idx) : 7'h7F;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 5;
      end else begin
        m_cnt++;
      end
      if (m_conv == 0) begin
        if (m_pending || int'(score) != m_shadow) begin
          m_cap     = int'(score);
          m_shadow  = int'(score);
          m_pending = 1'b0;
          m_conv    = 17;
        end
      end else begin
        m_conv--;
        if (m_conv == 0) begin
          m_val   = m_cap;
          m_valid = 1'b1;
        end
      end
    end
  end

  task automatic check_outputs();
    chk("bcd",       32'(bcd),       32'(to_bcd(m_val)));
    chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
    chk("busy",      32'(busy),      32'(m_conv != 0));
    chk("an",        32'(an),        32'(m_an));
    chk("seg",       32'(seg),       32'(m_seg));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    rst = 1'b1; score = 16'd0;
    run(3);
    rst = 1'b0;
    run(40);
    score = 16'd65535;
    run(60);
    score = 16'd200;
    run(6);
    score = 16'd300;
    run(50);
    score = 16'd1234;
    run(9);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    score = 16'd50;
    run(45);
    score = 16'd0;
    run(45);
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) score = 16'($urandom_range(0, 999));
      else                           score = 16'($urandom);
      run($urandom_range(1, 40));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
